// File: rtl/traffic_phase_sequencer.sv
// Timed RED -> GREEN -> YELLOW signal sequencer with one-hot lamp code and per-change advance pulse.
// Optional pedestrian latch / early GREEN end / WALK built when PED_WALK_EN is defined.
module traffic_phase_sequencer #(
  parameter int RED_TICKS       = 8,
  parameter int GREEN_TICKS     = 6,
  parameter int YELLOW_TICKS    = 2,
  parameter int MIN_GREEN_TICKS = 2,
  parameter int CNT_W           = 8
) (
  input  logic       clock_i,
  input  logic       reset_n_i,
  input  logic       tick_i,
  input  logic       enable_i,
  input  logic       ped_req_i,
  output logic [0:2] light_o,
  output logic [1:0] phase_o,
  output logic       advance_o,
  output logic       ped_ack_o,
  output logic       walk_o
);

  localparam logic [1:0] PH_RED    = 2'd0;
  localparam logic [1:0] PH_GREEN  = 2'd1;
  localparam logic [1:0] PH_YELLOW = 2'd2;

  logic [1:0]       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             walk_q, walk_d;
  logic [0:2]       light_q, light_d;
  logic             advance_q, advance_d;
  logic             ped_ack_q, ped_ack_d;

  logic             step;
  logic             new_req;
  logic             last_cnt;
  logic             early_end;
  logic [CNT_W-1:0] cnt_last;

  assign step = tick_i & enable_i;

`ifdef PED_WALK_EN
  // A request seen while the current RED already shows WALK is dropped; the requester must hold it.
  assign new_req = ped_req_i & ~pending_q & ~((phase_q == PH_RED) & walk_q);
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req_i;
  assign new_req        = 1'b0;
`endif

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      phase_q   <= PH_RED;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      walk_q    <= 1'b0;
      light_q   <= 3'b100;
      advance_q <= 1'b0;
      ped_ack_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      walk_q    <= walk_d;
      light_q   <= light_d;
      advance_q <= advance_d;
      ped_ack_q <= ped_ack_d;
    end
  end

  always_comb begin
    cnt_last = '0;
    case (phase_q)
      PH_RED:    cnt_last = CNT_W'(RED_TICKS - 1);
      PH_GREEN:  cnt_last = CNT_W'(GREEN_TICKS - 1);
      PH_YELLOW: cnt_last = CNT_W'(YELLOW_TICKS - 1);
      default:   cnt_last = '0;
    endcase
  end

  assign last_cnt  = (cnt_q == cnt_last);
  assign early_end = pending_q & (cnt_q >= CNT_W'(MIN_GREEN_TICKS - 1));

  always_comb begin
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    pending_d = pending_q | new_req;
    walk_d    = walk_q;
    case (phase_q)
      PH_RED: begin
        if (step) begin
          if (last_cnt) begin
            phase_d = PH_GREEN;
            cnt_d   = '0;
            walk_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      PH_GREEN: begin
        if (step) begin
          if (last_cnt || early_end) begin
            phase_d = PH_YELLOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      PH_YELLOW: begin
        if (step) begin
          if (last_cnt) begin
            phase_d   = PH_RED;
            cnt_d     = '0;
            walk_d    = pending_q | new_req;
            pending_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        phase_d = PH_RED;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so lamp, phase and advance move on one edge.
  always_comb begin
    advance_d = (phase_d != phase_q);
    ped_ack_d = new_req;
    case (phase_d)
      PH_GREEN:  light_d = 3'b010;
      PH_YELLOW: light_d = 3'b001;
      default:   light_d = 3'b100;
    endcase
  end

  assign light_o   = light_q;
  assign phase_o   = phase_q;
  assign advance_o = advance_q;
  assign ped_ack_o = ped_ack_q;
  assign walk_o    = walk_q;

endmodule
